// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one pipelined vectoring CORDIC core between N_REQ requesters.
// Optional watchdog flush of lost operations when CORDIC_ARB_TIMEOUT_EN is defined.
module cordic_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [N_REQ-1:0]                req_valid_in,
  input  logic [N_REQ*DATA_WIDTH-1:0]     req_data_in,
  output logic [N_REQ-1:0]                req_ready_out,
  output logic [N_REQ*DATA_WIDTH/2-1:0]   res_angle_out,
  output logic [N_REQ-1:0]                res_valid_out,
  input  logic [N_REQ-1:0]                res_ready_in,
  output logic [DATA_WIDTH-1:0]           cordic_tdata_out,
  output logic                            cordic_tvalid_out,
  input  logic                            cordic_tready_in,
  input  logic [DATA_WIDTH-1:0]           cordic_dout_in,
  input  logic                            cordic_dout_valid_in,
  output logic                            err_out
);

  localparam int unsigned N     = N_REQ;
  localparam int          TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          CNT_W = $clog2(N_REQ + 1);
  localparam int          HW    = DATA_WIDTH / 2;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} slot_state_t;

  slot_state_t      slot_q [N_REQ];
  slot_state_t      slot_d [N_REQ];
  logic [HW-1:0]    angle_q [N_REQ];
  logic [TAG_W-1:0] fifo_q [N_REQ];

  logic [TAG_W-1:0] rr_q, lock_slot_q, rd_ptr_q, wr_ptr_q;
  logic [TAG_W-1:0] pick, grant, pop_tag;
  logic [CNT_W-1:0] count_q;
  logic [N_REQ-1:0] eligible;
  logic             lock_q, lock_hold, lock_drop, found, grant_vld;
  logic             hs, pop, dout_orphan, flush, err_q;
  logic             dout_unused;

  assign dout_unused = ^cordic_dout_in[HW-1:0];

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < N; i++)
      eligible[i] = (slot_q[i] == IDLE) && req_valid_in[i];
  end

  // A slot stalled by tready stays granted even if a higher-priority slot turns eligible.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr_q) + k) % N;
      if (!found && eligible[idx[TAG_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[TAG_W-1:0];
      end
    end
    lock_hold = lock_q && req_valid_in[lock_slot_q];
    lock_drop = lock_q && !req_valid_in[lock_slot_q];
    grant     = lock_hold ? lock_slot_q : pick;
    grant_vld = rst_n_in && (lock_hold || found);
  end

  always_comb begin
    cordic_tvalid_out = grant_vld;
    hs                = grant_vld && cordic_tready_in;
    cordic_tdata_out  = '0;
    req_ready_out     = '0;
    for (int unsigned i = 0; i < N; i++)
      if (grant == TAG_W'(i))
        cordic_tdata_out = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    if (hs)
      req_ready_out[grant] = 1'b1;
  end

  assign pop         = cordic_dout_valid_in && (count_q != '0);
  assign dout_orphan = cordic_dout_valid_in && (count_q == '0);
  assign pop_tag     = fifo_q[rd_ptr_q];

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      slot_d[i] = slot_q[i];
      unique case (slot_q[i])
        IDLE:     if (hs && grant == TAG_W'(i)) slot_d[i] = INFLIGHT;
        INFLIGHT: begin
          if (flush)                                  slot_d[i] = IDLE;
          else if (pop && pop_tag == TAG_W'(i))       slot_d[i] = DONE;
        end
        DONE:     if (res_ready_in[i]) slot_d[i] = IDLE;
        default:  slot_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < N; i++) begin
        slot_q[i]  <= IDLE;
        angle_q[i] <= '0;
        fifo_q[i]  <= '0;
      end
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++)
        slot_q[i] <= slot_d[i];
      lock_q      <= grant_vld && !cordic_tready_in;
      lock_slot_q <= grant;
      if (hs)
        rr_q <= ptr_inc(grant);
      if (lock_drop || dout_orphan || flush)
        err_q <= 1'b1;
      if (pop)
        angle_q[pop_tag] <= cordic_dout_in[DATA_WIDTH-1:HW];
      // A flush empties the FIFO but must still keep a same-cycle new request.
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= hs ? ptr_inc('0) : '0;
        count_q  <= hs ? CNT_W'(1) : '0;
        if (hs)
          fifo_q[0] <= grant;
      end else begin
        if (hs) begin
          fifo_q[wr_ptr_q] <= grant;
          wr_ptr_q         <= ptr_inc(wr_ptr_q);
        end
        if (pop)
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (hs && !pop)
          count_q <= count_q + 1'b1;
        else if (!hs && pop)
          count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  logic [31:0] tcnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      tcnt_q <= '0;
    else if (pop || flush || count_q == '0)
      tcnt_q <= '0;
    else
      tcnt_q <= tcnt_q + 1'b1;
  end

  assign flush = (count_q != '0) && !pop && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign flush          = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      res_valid_out[i]             = (slot_q[i] == DONE);
      res_angle_out[i*HW +: HW]    = angle_q[i];
    end
  end

  assign err_out = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model with a fixed-latency core model.
module tb_cordic_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, res_valid, res_ready;
  logic [N*DW-1:0]   req_data;
  logic [N*DW/2-1:0] res_angle;
  logic [DW-1:0]     tdata, dout;
  logic              tvalid, tready, dout_valid, err;
  logic [DW-1:0]     sdata [N];

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = sdata[i];

  cordic_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_data_in(req_data), .req_ready_out(req_ready),
    .res_angle_out(res_angle), .res_valid_out(res_valid), .res_ready_in(res_ready),
    .cordic_tdata_out(tdata), .cordic_tvalid_out(tvalid), .cordic_tready_in(tready),
    .cordic_dout_in(dout), .cordic_dout_valid_in(dout_valid), .err_out(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: slot status 0=free 1=waiting for core 2=result held
  int          m_st [N];
  int          m_rr, m_lslot, p_grant;
  bit          m_lock, m_err, model_on, hang, inject, hs_seen;
  int          m_tags [$];
  logic [15:0] m_ang [N];
  logic [DW-1:0] hs_data;
  logic [N-1:0]  rdy_seen;
  int          grants [$];
  int          edge_no = 0;

  typedef struct { int due; logic [DW-1:0] d; } core_op_t;
  core_op_t pipe [$];

  function automatic logic [15:0] angle_fn(input logic [DW-1:0] d);
    if (d == 32'h0100_0100) return 16'h1922;
    return d[31:16] ^ {d[7:0], d[15:8]} ^ 16'h5a5a;
  endfunction

  function automatic int model_grant();
    if (m_lock && req_valid[m_lslot]) return m_lslot;
    for (int k = 0; k < N; k++) begin
      int s = (m_rr + k) % N;
      if (m_st[s] == 0 && req_valid[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_ang[i] = '0; end
    m_rr = 0; m_lock = 0; m_lslot = 0; m_err = 0; hang = 0; inject = 0;
    m_tags.delete(); pipe.delete();
    dout_valid = 1'b0; dout = '0;
  endtask

  task automatic model_update();
    if (m_lock && !req_valid[m_lslot]) m_err = 1;
    for (int i = 0; i < N; i++) if (m_st[i] == 2 && res_ready[i]) m_st[i] = 0;
    if (dout_valid) begin
      if (m_tags.size() == 0) m_err = 1;
      else begin
        int t = m_tags.pop_front();
        m_st[t] = 2; m_ang[t] = dout[31:16];
      end
    end
    if (p_grant >= 0 && tready) begin
      m_st[p_grant] = 1; m_tags.push_back(p_grant); m_rr = (p_grant + 1) % N;
    end
    m_lock = (p_grant >= 0) && !tready;
    m_lslot = (p_grant >= 0) ? p_grant : 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]    er, ev;
    logic [N*16-1:0] ea;
    hs_seen = tvalid && tready; hs_data = tdata; rdy_seen = req_ready;
    for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    p_grant = model_grant();
    if (!model_on) return;
    er = '0;
    if (p_grant >= 0 && tready) er[p_grant] = 1'b1;
    for (int i = 0; i < N; i++) begin ev[i] = (m_st[i] == 2); ea[i*16 +: 16] = m_ang[i]; end
    chk("m_tvalid", tvalid, p_grant >= 0);
    if (p_grant >= 0) chk("m_tdata", tdata, sdata[p_grant]);
    chk("m_req_ready", req_ready, er);
    chk("m_res_valid", res_valid, ev);
    chk("m_res_angle", res_angle, ea);
    chk("m_err", err, m_err);
  endtask

  task automatic step(input logic [N-1:0] v, input logic tr, input logic [N-1:0] rr);
    req_valid = v; tready = tr; res_ready = rr;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk); #1;
    edge_no++;
    if (model_on) model_update();
    if (hs_seen) pipe.push_back('{edge_no + LAT, hs_data});
    dout_valid = 1'b0; dout = '0;
    if (inject) begin
      dout_valid = 1'b1; dout = 32'hdead_beef; inject = 0;
    end else if (pipe.size() > 0 && pipe[0].due == edge_no) begin
      core_op_t op = pipe.pop_front();
      if (!hang) begin dout_valid = 1'b1; dout = {angle_fn(op.d), op.d[15:0]}; end
    end
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic tr, input logic [N-1:0] rr);
    step(v, tr, rr); advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '1; tready = 1'b1; res_ready = '0; #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_angle", res_angle, 0);
    chk("rst_err", err, 0);
    model_reset(); hs_seen = 0;
    @(posedge clk); @(posedge clk); #1;
    req_valid = '0; rst_n = 1'b1;
  endtask

  typedef struct { logic [N-1:0] v; logic tr; logic tv; logic [N-1:0] rdy; int slot; } vec_t;
  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  h, lat;
    bit  got;
    logic [N-1:0] nv;

    // grant sequence from reset: lock on slot 2 must hold off slot 0 while tready is low
    tbl[0]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, -1};
    tbl[1]  = '{4'b1000, 1'b1, 1'b1, 4'b1000,  3};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0000,  2};
    tbl[3]  = '{4'b0101, 1'b0, 1'b1, 4'b0000,  2};
    tbl[4]  = '{4'b0101, 1'b0, 1'b1, 4'b0000,  2};
    tbl[5]  = '{4'b0101, 1'b0, 1'b1, 4'b0000,  2};
    tbl[6]  = '{4'b0101, 1'b0, 1'b1, 4'b0000,  2};
    tbl[7]  = '{4'b0101, 1'b1, 1'b1, 4'b0100,  2};
    tbl[8]  = '{4'b0101, 1'b1, 1'b1, 4'b0001,  0};
    tbl[9]  = '{4'b0111, 1'b1, 1'b1, 4'b0010,  1};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, -1};

    rst_n = 1'b1; req_valid = '0; res_ready = '0; tready = 1'b0;
    dout_valid = 1'b0; dout = '0; model_on = 0; hang = 0; inject = 0;
    for (int i = 0; i < N; i++) sdata[i] = {16'h1100 * 16'(i + 1), 16'h0011 * 16'(i + 1)};
    #2;

    // single request on slot 1
    do_reset(); model_on = 1;
    sdata[1] = 32'h0100_0100;
    step(4'b0010, 1'b1, 4'b0000);
    chk("single_hs", req_ready, 4'b0010);
    advance(); h = edge_no; lat = -1;
    for (int k = 0; k < 40; k++) begin
      step(4'b0010, 1'b1, 4'b0000);
      chk("single_no_regrant", req_ready, 4'b0000);
      if (res_valid[1]) begin lat = edge_no - h; advance(); break; end
      advance();
    end
    chk("single_latency", lat, 21);
    chk("single_angle", res_angle[31:16], 16'h1922);
    cyc(4'b0000, 1'b1, 4'b0010);
    step(4'b0000, 1'b1, 4'b0000);
    chk("single_consumed", res_valid, 4'b0000);
    chk("single_angle_kept", res_angle[31:16], 16'h1922);
    advance();

    // table vectors
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].tr, 4'b1111);
      chk($sformatf("tbl%0d_tvalid", k), tvalid, tbl[k].tv);
      chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].rdy);
      if (tbl[k].slot >= 0) chk($sformatf("tbl%0d_tdata", k), tdata, sdata[tbl[k].slot]);
      advance();
    end
    repeat (30) cyc(4'b0000, 1'b1, 4'b1111);

    // fairness
    do_reset(); grants.delete();
    repeat (120) cyc(4'b1111, 1'b1, 4'b1111);
    chk("fair_count", grants.size() >= 16, 1);
    foreach (grants[k]) chk($sformatf("fair_order%0d", k), grants[k], k % N);
    repeat (30) cyc(4'b0000, 1'b1, 4'b1111);

    // unconsumed result on slot 3 blocks re-grant until consumed
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(4'b1000, 1'b1, 4'b0000); got = req_ready[3]; advance();
    end
    chk("unc_grant", got, 1);
    got = 0;
    for (int k = 0; k < 40; k++) begin
      step(4'b1000, 1'b1, 4'b0000);
      chk("unc_busy", req_ready, 4'b0000);
      if (res_valid[3]) begin got = 1; advance(); break; end
      advance();
    end
    chk("unc_done", got, 1);
    repeat (5) begin
      step(4'b1000, 1'b1, 4'b0000);
      chk("unc_hold_ready", req_ready, 4'b0000);
      chk("unc_hold_valid", res_valid[3], 1);
      advance();
    end
    step(4'b1000, 1'b1, 4'b1000);
    chk("unc_consume_tvalid", tvalid, 0);
    chk("unc_consume_ready", req_ready, 4'b0000);
    advance();
    step(4'b1000, 1'b1, 4'b0000);
    chk("unc_regrant", req_ready, 4'b1000);
    advance();
    repeat (30) cyc(4'b0000, 1'b1, 4'b1111);

    // randomized traffic; requesters hold valid/data until accepted
    for (int c = 0; c < 1500; c++) begin
      nv = req_valid;
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && !rdy_seen[i])) begin
          nv[i] = ($urandom_range(0, 99) < 60);
          sdata[i] = $urandom();
        end
      step(nv, $urandom_range(0, 3) != 0, N'($urandom()));
      advance();
    end
    repeat (30) cyc(4'b0000, 1'b1, 4'b1111);

    // result with no outstanding operation
    inject = 1;
    cyc(4'b0000, 1'b1, 4'b1111);
    cyc(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk("orphan_err", err, 1);
    chk("orphan_res_valid", res_valid, 4'b0000);
    advance();

    // reset while results held and an operation is in flight
    do_reset();
    inject = 1;
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0010, 1'b1, 4'b0000);
    repeat (25) cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0001, 1'b1, 4'b0000);
    step(4'b0100, 1'b1, 4'b0000);
    chk("pre_rst_res_valid", res_valid, 4'b0010);
    chk("pre_rst_err", err, 1);
    advance();
    do_reset();

`ifdef CORDIC_ARB_TIMEOUT_EN
    // core never answers: watchdog flushes and the slot is granted again
    model_on = 0; hang = 1;
    step(4'b0001, 1'b1, 4'b0000);
    chk("to_hs", req_ready, 4'b0001);
    advance(); h = edge_no;
    while (edge_no - h < 64) begin
      step(4'b0001, 1'b1, 4'b0000);
      chk("to_err_early", err, 0);
      chk("to_busy", req_ready, 4'b0000);
      advance();
    end
    step(4'b0001, 1'b1, 4'b0000);
    chk("to_err", err, 1);
    chk("to_regrant", req_ready, 4'b0001);
    advance();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
